// File: rtl/csc_pipe_if.sv
// csc_pipe_if: pixel stream handshake between pixel source, converter and sink
interface csc_pipe_if #(parameter int DW = 8);
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [DW-1:0] in_c0, in_c1, in_c2, out_c0, out_c1, out_c2;
  logic [1:0] in_mode, out_mode;
  modport master (
    output in_valid, in_c0, in_c1, in_c2, in_mode, in_last, out_ready,
    input in_ready, out_valid, out_c0, out_c1, out_c2, out_mode, out_last
  );
  modport slave (
    input in_valid, in_c0, in_c1, in_c2, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_c0, out_c1, out_c2, out_mode, out_last
  );
endinterface

// File: rtl/csc_pipe.sv
// csc_pipe: 3-stage per-pixel-mode colour-space converter with rounding, saturation and stream back-pressure
module csc_pipe #(
  parameter int DW = 8,
  parameter int FRAC = 8
) (
  input logic clk,
  input logic rst,
  csc_pipe_if.slave px
);
  localparam int W = DW + FRAC + 4;
  localparam int O = 1 << (DW - 8);
  // mode 3 uses a unity diagonal so bypass shares the datapath and rounds exactly
  localparam int K8 [4][9] = '{
    '{66, 129, 25, -38, -74, 112, 112, -94, -18},
    '{77, 150, 29, -43, -85, 128, 128, -107, -21},
    '{298, 0, 409, 298, -100, -208, 298, 516, 0},
    '{256, 0, 0, 0, 256, 0, 0, 0, 256}
  };
  localparam int OFS [4][3] = '{
    '{16 * O, 128 * O, 128 * O},
    '{0, 128 * O, 128 * O},
    '{0, 0, 0},
    '{0, 0, 0}
  };
  localparam logic signed [W-1:0] YO = W'(16 * O);
  localparam logic signed [W-1:0] CO = W'(128 * O);
  localparam logic signed [W-1:0] HALF = W'(1 << (FRAC - 1));
  localparam logic signed [W-1:0] MAXV = W'((1 << DW) - 1);
  logic adv, v1, v2, l1, l2;
  logic [1:0] m1, m2;
  logic signed [W-1:0] a [3];
  logic signed [W-1:0] p_n [9];
  logic signed [W-1:0] p [9];
  logic signed [W-1:0] s [3];
  logic signed [W-1:0] r [3];
  logic [DW-1:0] q [3];
  assign adv = !px.out_valid || px.out_ready;
  assign px.in_ready = adv;
  always_comb begin
    a[0] = $signed(W'(px.in_c0)) - (px.in_mode == 2'd2 ? YO : '0);
    a[1] = $signed(W'(px.in_c1)) - (px.in_mode == 2'd2 ? CO : '0);
    a[2] = $signed(W'(px.in_c2)) - (px.in_mode == 2'd2 ? CO : '0);
    for (int i = 0; i < 9; i++)
      p_n[i] = W'(K8[px.in_mode][i] * (1 << FRAC) / 256 * int'(a[i % 3]));
  end
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      r[i] = ((s[i] + HALF) >>> FRAC) + $signed(W'(OFS[m2][i]));
      q[i] = r[i] < 0 ? '0 : (r[i] > MAXV ? '1 : r[i][DW-1:0]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      px.out_valid <= 1'b0;
      px.out_c0 <= '0;
      px.out_c1 <= '0;
      px.out_c2 <= '0;
      px.out_mode <= '0;
      px.out_last <= 1'b0;
    end else if (adv) begin
      v1 <= px.in_valid;
      p <= p_n;
      m1 <= px.in_mode;
      l1 <= px.in_last;
      v2 <= v1;
      for (int i = 0; i < 3; i++) s[i] <= p[3*i] + p[3*i+1] + p[3*i+2];
      m2 <= m1;
      l2 <= l1;
      px.out_valid <= v2;
      px.out_c0 <= q[0];
      px.out_c1 <= q[1];
      px.out_c2 <= q[2];
      px.out_mode <= m2;
      px.out_last <= l2;
    end
  end
endmodule

// File: tb/tb_csc_pipe.sv
// tb_csc_pipe: directed and random back-pressure checks of csc_pipe against a scoreboard
module tb_csc_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  csc_pipe_if #(.DW(8)) ifc();
  csc_pipe #(.DW(8), .FRAC(8)) dut (.clk(clk), .rst(rst), .px(ifc));
  typedef struct {int c0, c1, c2, m; bit l; int cyc; bit lat;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit lat_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int rnd(int x);
    return (x + 128) >>> 8;
  endfunction
  function automatic int clip(int x);
    return x < 0 ? 0 : (x > 255 ? 255 : x);
  endfunction
  function automatic exp_t model(int m, int a, int b, int c, bit l);
    exp_t e;
    int y, u, v;
    y = a - 16; u = b - 128; v = c - 128;
    e.m = m; e.l = l; e.cyc = cyc; e.lat = lat_on;
    if (m == 0) begin
      e.c0 = clip(16 + rnd(66*a + 129*b + 25*c));
      e.c1 = clip(128 + rnd(-38*a - 74*b + 112*c));
      e.c2 = clip(128 + rnd(112*a - 94*b - 18*c));
    end else if (m == 1) begin
      e.c0 = clip(rnd(77*a + 150*b + 29*c));
      e.c1 = clip(128 + rnd(-43*a - 85*b + 128*c));
      e.c2 = clip(128 + rnd(128*a - 107*b - 21*c));
    end else if (m == 2) begin
      e.c0 = clip(rnd(298*y + 409*v));
      e.c1 = clip(rnd(298*y - 100*u - 208*v));
      e.c2 = clip(rnd(298*y + 516*u));
    end else begin
      e.c0 = a; e.c1 = b; e.c2 = c;
    end
    return e;
  endfunction
  task automatic send(int m, int a, int b, int c, bit l, int e0, int e1, int e2);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_mode = 2'(m);
    ifc.in_c0 = 8'(a);
    ifc.in_c1 = 8'(b);
    ifc.in_c2 = 8'(c);
    ifc.in_last = l;
    @(negedge clk);
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ifc.in_ready) q.push_back('{e0, e1, e2, m, l, cyc, lat_on});
    else check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain_timeout", q.size(), 0);
  endtask
  task automatic check_reset_outputs();
    check("rst_valid", ifc.out_valid, 0);
    check("rst_c0", ifc.out_c0, 0);
    check("rst_c1", ifc.out_c1, 0);
    check("rst_c2", ifc.out_c2, 0);
    check("rst_mode", ifc.out_mode, 0);
    check("rst_last", ifc.out_last, 0);
  endtask
  initial begin
    exp_t e;
    bit hold = 1'b0;
    logic [7:0] h0, h1, h2;
    logic [1:0] hm;
    logic hl;
    forever begin
      @(negedge clk);
      if (rst) hold = 1'b0;
      else begin
        check("in_ready", ifc.in_ready, !ifc.out_valid || ifc.out_ready);
        if (hold) begin
          check("hold_valid", ifc.out_valid, 1);
          check("hold_c0", ifc.out_c0, h0);
          check("hold_c1", ifc.out_c1, h1);
          check("hold_c2", ifc.out_c2, h2);
          check("hold_mode", ifc.out_mode, hm);
          check("hold_last", ifc.out_last, hl);
        end
        if (ifc.out_valid && ifc.out_ready) begin
          if (q.size() == 0) check("unexpected_out", ifc.out_valid, 0);
          else begin
            e = q.pop_front();
            check("c0", ifc.out_c0, e.c0);
            check("c1", ifc.out_c1, e.c1);
            check("c2", ifc.out_c2, e.c2);
            check("mode", ifc.out_mode, e.m);
            check("last", ifc.out_last, e.l);
            if (e.lat) check("latency", cyc - e.cyc, 3);
          end
        end
        hold = ifc.out_valid && !ifc.out_ready;
        h0 = ifc.out_c0; h1 = ifc.out_c1; h2 = ifc.out_c2;
        hm = ifc.out_mode; hl = ifc.out_last;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_t e;
    int m, a, b, c;
    bit l;
    ifc.in_valid = 1'b0;
    ifc.in_mode = '0;
    ifc.in_c0 = '0;
    ifc.in_c1 = '0;
    ifc.in_c2 = '0;
    ifc.in_last = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b0;
    lat_on = 1'b1;
    send(0, 255, 255, 255, 0, 235, 128, 128);
    send(0, 0, 0, 0, 0, 16, 128, 128);
    send(0, 255, 0, 0, 1, 82, 90, 240);
    send(1, 255, 255, 255, 0, 255, 128, 128);
    send(2, 235, 128, 128, 0, 255, 255, 255);
    send(2, 16, 128, 128, 1, 0, 0, 0);
    send(2, 235, 128, 240, 0, 255, 164, 255);
    send(2, 16, 128, 16, 1, 0, 91, 0);
    repeat (2) @(posedge clk);
    #1;
    send(0, 255, 0, 0, 0, 82, 90, 240);
    send(3, 12, 34, 56, 1, 12, 34, 56);
    send(2, 235, 128, 128, 0, 255, 255, 255);
    send(1, 255, 255, 255, 1, 255, 128, 128);
    drain();
    lat_on = 1'b0;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      m = $urandom_range(0, 3);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      l = 1'($urandom_range(0, 1));
      ifc.in_mode = 2'(m);
      ifc.in_c0 = 8'(a);
      ifc.in_c1 = 8'(b);
      ifc.in_c2 = 8'(c);
      ifc.in_last = l;
      ifc.out_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (ifc.in_ready) begin
        e = model(m, a, b, c, l);
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    drain();
    ifc.out_ready = 1'b0;
    send(0, 255, 255, 255, 0, 235, 128, 128);
    send(1, 255, 255, 255, 1, 255, 128, 128);
    send(3, 1, 2, 3, 0, 1, 2, 3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs();
    q.delete();
    ifc.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 lat_on = 1'b1;
    send(3, 12, 34, 56, 1, 12, 34, 56);
    drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csc_pipe.md
Name: csc_pipe

Overview:
- Parametrised, pipelined colour-space converter. Successor to the fixed 8-bit, single-mode, single-cycle RGB to YCbCr converter.
- Adds generic data width, per-pixel mode select (forward limited range, forward full range, inverse limited range, bypass), round-to-nearest arithmetic and output saturation.
- Adds a valid/ready stream handshake with back-pressure and a pass-through end-of-line flag.
- Sits between the pixel source/line buffers and the downstream filter/compression stages of the image pipeline.

Parameters:
- DW, 8, bits per colour component, in and out; legal range 8..12.
- FRAC, 8, fractional bits of the fixed-point coefficients; coefficients below are given for FRAC=8.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts the pixel this cycle
- in_c0, in_c1, in_c2  in  DW each  input components: R,G,B (modes 0/1/3) or Y,Cb,Cr (mode 2)
- in_mode  in  2  conversion mode; sampled with the pixel
- in_last  in  1  end-of-line marker; travels with the pixel
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_c0, out_c1, out_c2  out  DW each  output components: Y,Cb,Cr (modes 0/1), R,G,B (mode 2), copy (mode 3)
- out_mode  out  2  mode the pixel was converted with
- out_last  out  1  delayed in_last

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valids clear.
  - out_valid=0; out_c0/c1/c2=0; out_mode=0; out_last=0.
  - Pixels in flight are discarded; no partial output appears after reset.
- Pipeline: 3 register stages.
  - S1 registers the nine signed products, mode and last.
  - S2 registers the three sums.
  - S3 adds rounding and offset, shifts, clamps and drives the outputs.
  - Latency is 3 cycles from acceptance to out_valid with no stall. Throughput is 1 pixel/clk.
- Handshake:
  - Global advance enable adv = !out_valid || out_ready.
  - in_ready = adv, combinational; no combinational path from in_valid to in_ready.
  - A transfer occurs when in_valid && in_ready.
  - When adv=0, all stages hold, including out data; out_valid stays high until out_ready.
  - Bubbles are not collapsed.
  - out_c*, out_mode and out_last are stable whenever out_valid=1 and out_ready=0.
- Mode is carried per pixel. Changing in_mode between consecutive pixels is legal; each pixel uses its own mode.
- Arithmetic, with O = 2^(DW-8) scaling of the 8-bit offsets:
  - Mode 0 (BT.601 limited, forward):
    - Y = 16*O + rnd(66R+129G+25B)
    - Cb = 128*O + rnd(-38R-74G+112B)
    - Cr = 128*O + rnd(112R-94G-18B)
  - Mode 1 (full range, forward):
    - Y = rnd(77R+150G+29B)
    - Cb = 128*O + rnd(-43R-85G+128B)
    - Cr = 128*O + rnd(128R-107G-21B)
  - Mode 2 (limited, inverse), with y = Y-16*O, u = Cb-128*O, v = Cr-128*O computed in S1:
    - R = rnd(298y+409v)
    - G = rnd(298y-100u-208v)
    - B = rnd(298y+516u)
  - Mode 3: out_c* = in_c*, delayed 3 cycles.
  - rnd(x) = (x + 2^(FRAC-1)) >>> FRAC, an arithmetic shift, i.e. floor after adding half.
  - Internal signed width is DW+FRAC+4 bits, which is sufficient, so no internal overflow.
- Saturation: every output is clamped to [0, 2^DW-1] in all modes. No clamping to the 16..235 limited band.
- in_valid=0 cycles insert bubbles. out_valid is never asserted for a bubble.

Test Plan:
- Mode 0, DW=8, back-to-back pixels, out_ready=1:
  - (255,255,255) -> (235,128,128)
  - (0,0,0) -> (16,128,128)
  - (255,0,0) -> (82,90,240)
  - Each appears exactly 3 cycles after acceptance.
- Mode 1 and mode 2:
  - Mode 1 (255,255,255) -> (255,128,128).
  - Mode 2 (235,128,128) -> (255,255,255).
  - Mode 2 (16,128,128) -> (0,0,0).
- Saturation, mode 2:
  - (235,128,240) -> (255,164,255), high clamp on R.
  - (16,128,16) -> (0,91,0), low clamp on R.
- Back-pressure:
  - Random out_ready at a 30% duty with in_valid held high.
  - in_ready must equal adv.
  - Output data must be held stable while stalled; no pixel is lost or duplicated.
  - The output sequence must match a scoreboard model, including in_last to out_last alignment.
- Per-pixel mode interleave:
  - Modes 0,3,2,1 on consecutive cycles.
  - Each result must match its own mode, and out_mode must echo the input mode.
  - Mode 3 (12,34,56) -> (12,34,56).
- Reset mid-stream:
  - Assert rst with 3 pixels in flight and out_ready=0.
  - Next cycle: out_valid=0 and outputs are 0.
  - No stale pixel emerges afterwards; the first post-reset pixel has latency 3.
